// File: rtl/cache_control_if.sv
// Bundle of CPU, datapath, pmem and counter signals between the cache controller
// and its environment. The controller uses the slave modport.
interface cache_control_if #(parameter int CNT_W = 16);
  logic             mem_read;
  logic             mem_write;
  logic             mem_resp;
  logic             hit;
  logic             dirty;
  logic             dp_read;
  logic             dp_write;
  logic             dp_fill;
  logic             pmem_addr_sel;
  logic             pmem_read;
  logic             pmem_write;
  logic             pmem_resp;
  logic             cnt_clr;
  logic [CNT_W-1:0] hit_count;
  logic [CNT_W-1:0] miss_count;

  modport master (
    output mem_read, mem_write, hit, dirty, pmem_resp, cnt_clr,
    input  mem_resp, dp_read, dp_write, dp_fill, pmem_addr_sel, pmem_read, pmem_write,
           hit_count, miss_count
  );

  modport slave (
    input  mem_read, mem_write, hit, dirty, pmem_resp, cnt_clr,
    output mem_resp, dp_read, dp_write, dp_fill, pmem_addr_sel, pmem_read, pmem_write,
           hit_count, miss_count
  );
endinterface

// File: rtl/cache_control.sv
// Sequencer for the 2-way cache_set datapath: hit check, dirty writeback, line fill,
// plus saturating hit/miss counters.
module cache_control #(
  parameter int CNT_W = 16
) (
  input logic            clk,
  input logic            rst,
  cache_control_if.slave bus
);

  typedef enum logic [1:0] {IDLE, COMPARE, WRITEBACK, FILL} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           state_q, state_d;
  logic             op_is_write_q, op_is_write_d;
  logic             refill_q, refill_d;
  logic             dp_read_q, dp_read_d;
  logic             pmem_read_q, pmem_read_d;
  logic             pmem_write_q, pmem_write_d;
  logic             pmem_addr_sel_q, pmem_addr_sel_d;
  logic [CNT_W-1:0] hit_count_q, hit_count_d;
  logic [CNT_W-1:0] miss_count_q, miss_count_d;

  logic cmp_hit;
  logic cmp_miss;

  assign cmp_hit  = (state_q == COMPARE) && bus.hit;
  assign cmp_miss = (state_q == COMPARE) && !bus.hit;

  always_comb begin
    state_d       = state_q;
    op_is_write_d = op_is_write_q;
    refill_d      = refill_q;

    case (state_q)
      IDLE: begin
        if (bus.mem_read || bus.mem_write) begin
          op_is_write_d = bus.mem_write;
          state_d       = COMPARE;
        end
      end
      COMPARE: begin
        if (bus.hit)        state_d = IDLE;
        else if (bus.dirty) state_d = WRITEBACK;
        else                state_d = FILL;
      end
      WRITEBACK: begin
        if (bus.pmem_resp) state_d = FILL;
      end
      FILL: begin
        if (bus.pmem_resp) begin
          state_d  = COMPARE;
          refill_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (state_d == IDLE) refill_d = 1'b0;

    // Moore outputs are registered from the next state so they come straight off flops.
    dp_read_d       = (state_d == COMPARE) || (state_d == WRITEBACK);
    pmem_write_d    = (state_d == WRITEBACK);
    pmem_read_d     = (state_d == FILL);
    pmem_addr_sel_d = (state_d == WRITEBACK);

    hit_count_d = hit_count_q;
    if (bus.cnt_clr)
      hit_count_d = '0;
    else if (cmp_hit && !refill_q && (hit_count_q != CNT_MAX))
      hit_count_d = hit_count_q + 1'b1;

    miss_count_d = miss_count_q;
    if (bus.cnt_clr)
      miss_count_d = '0;
    else if (cmp_miss && (miss_count_q != CNT_MAX))
      miss_count_d = miss_count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      op_is_write_q   <= 1'b0;
      refill_q        <= 1'b0;
      dp_read_q       <= 1'b0;
      pmem_read_q     <= 1'b0;
      pmem_write_q    <= 1'b0;
      pmem_addr_sel_q <= 1'b0;
      hit_count_q     <= '0;
      miss_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      op_is_write_q   <= op_is_write_d;
      refill_q        <= refill_d;
      dp_read_q       <= dp_read_d;
      pmem_read_q     <= pmem_read_d;
      pmem_write_q    <= pmem_write_d;
      pmem_addr_sel_q <= pmem_addr_sel_d;
      hit_count_q     <= hit_count_d;
      miss_count_q    <= miss_count_d;
    end
  end

  // Completion and datapath strobes react in the same cycle as hit / pmem_resp.
  assign bus.mem_resp      = cmp_hit;
  assign bus.dp_write      = cmp_hit && op_is_write_q;
  assign bus.dp_fill       = (state_q == FILL) && bus.pmem_resp;
  assign bus.dp_read       = dp_read_q;
  assign bus.pmem_read     = pmem_read_q;
  assign bus.pmem_write    = pmem_write_q;
  assign bus.pmem_addr_sel = pmem_addr_sel_q;
  assign bus.hit_count     = hit_count_q;
  assign bus.miss_count    = miss_count_q;

endmodule

// File: tb/tb_cache_control.sv
// Self-checking bench for cache_control: directed vector table, randomized
// transactions against a transaction-level model, reset and saturation sequences.
module tb_cache_control;

  localparam int TIMEOUT = 200;

  logic clk = 1'b0;
  logic rst = 1'b1;

  cache_control_if #(.CNT_W(16)) b ();
  cache_control_if #(.CNT_W(2))  b2 ();

  cache_control #(.CNT_W(16)) dut   (.clk(clk), .rst(rst), .bus(b.slave));
  cache_control #(.CNT_W(2))  dut_s (.clk(clk), .rst(rst), .bus(b2.slave));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int exp_hits = 0;
  int exp_miss = 0;

  typedef struct {
    bit       wr;
    bit       both;
    int       nmiss;
    bit [1:0] dty;
    int       wl;
    int       fl;
    int       exp_lat;
    int       exp_fills;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Transaction-level model: each miss costs writeback (if dirty) + fill + re-compare.
  function automatic int model_lat(input int nmiss, input bit [1:0] dty, input int wl, input int fl);
    int l = 1;
    for (int i = 0; i < nmiss; i++) l += (dty[i] ? wl : 0) + fl + 1;
    return l;
  endfunction

  function automatic int model_wb_cycles(input int nmiss, input bit [1:0] dty, input int wl);
    int c = 0;
    for (int i = 0; i < nmiss; i++) c += dty[i] ? wl : 0;
    return c;
  endfunction

  function automatic void model_count(input int nmiss);
    if (nmiss == 0) exp_hits = (exp_hits < 65535) ? exp_hits + 1 : 65535;
    exp_miss = (exp_miss + nmiss > 65535) ? 65535 : exp_miss + nmiss;
  endfunction

  task automatic run_txn(input bit wr, input bit both, input int nmiss, input bit [1:0] dty,
                         input int wl, input int fl, input bit noise,
                         output int lat, output int fills, output int dpws,
                         output int rd_cyc, output int wr_cyc);
    int  cyc, cmps, wcnt, fcnt;
    bit  done;
    lat = -1; fills = 0; dpws = 0; rd_cyc = 0; wr_cyc = 0;
    cyc = 0; cmps = 0; wcnt = 0; fcnt = 0; done = 0;
    @(negedge clk);
    b.mem_write = wr | both;
    b.mem_read  = !wr | both;
    b.hit = 0; b.dirty = 0; b.pmem_resp = 0;
    while (!done && cyc < TIMEOUT) begin
      @(negedge clk);
      cyc++;
      b.hit = 0; b.dirty = 0; b.pmem_resp = 0;
      if (noise && cyc > 1) begin
        b.mem_read  = 1'($urandom_range(0, 1));
        b.mem_write = 1'($urandom_range(0, 1));
      end
      check("pmem_excl", 32'(b.pmem_read & b.pmem_write), 0);
      if (b.pmem_write) begin
        check("wb_addr_sel", 32'(b.pmem_addr_sel), 1);
        wr_cyc++; wcnt++;
        if (wcnt == wl) begin b.pmem_resp = 1; wcnt = 0; end
      end else if (b.pmem_read) begin
        check("fill_addr_sel", 32'(b.pmem_addr_sel), 0);
        rd_cyc++; fcnt++;
        if (fcnt == fl) begin b.pmem_resp = 1; fcnt = 0; end
      end else if (b.dp_read) begin
        b.hit   = (cmps >= nmiss);
        b.dirty = (cmps < 2) ? dty[cmps] : 1'b0;
        cmps++;
        if (noise) b.pmem_resp = 1'($urandom_range(0, 1));
      end
      #1;
      if (b.dp_fill)  fills++;
      if (b.dp_write) dpws++;
      if (b.mem_resp) begin lat = cyc; done = 1; end
    end
    if (!done) check("txn_timeout", 0, 1);
    @(posedge clk);
    #1;
    b.mem_read = 0; b.mem_write = 0; b.hit = 0; b.dirty = 0; b.pmem_resp = 0;
    check("idle_after_resp", 32'(b.dp_read | b.pmem_read | b.pmem_write), 0);
  endtask

  task automatic do_txn(input string tag, input bit wr, input bit both, input int nmiss,
                        input bit [1:0] dty, input int wl, input int fl, input bit noise,
                        input int exp_lat, input int exp_fills);
    int lat, fills, dpws, rdc, wrc;
    run_txn(wr, both, nmiss, dty, wl, fl, noise, lat, fills, dpws, rdc, wrc);
    model_count(nmiss);
    check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
    check({tag, "_fills"}, 32'(fills), 32'(exp_fills));
    check({tag, "_dp_write"}, 32'(dpws), 32'(wr | both));
    check({tag, "_rd_cycles"}, 32'(rdc), 32'(nmiss * fl));
    check({tag, "_wr_cycles"}, 32'(wrc), 32'(model_wb_cycles(nmiss, dty, wl)));
    check({tag, "_hit_count"}, 32'(b.hit_count), 32'(exp_hits));
    check({tag, "_miss_count"}, 32'(b.miss_count), 32'(exp_miss));
  endtask

  initial begin
    b.mem_read = 0; b.mem_write = 0; b.hit = 0; b.dirty = 0; b.pmem_resp = 0; b.cnt_clr = 0;
    b2.mem_read = 0; b2.mem_write = 0; b2.hit = 0; b2.dirty = 0; b2.pmem_resp = 0; b2.cnt_clr = 0;

    vecs[0] = '{0, 0, 0, 2'b00, 1, 1, 1, 0};   // read hit
    vecs[1] = '{1, 0, 0, 2'b00, 1, 1, 1, 0};   // write hit
    vecs[2] = '{0, 1, 0, 2'b00, 1, 1, 1, 0};   // read+write together: write wins
    vecs[3] = '{0, 0, 1, 2'b00, 1, 3, 5, 1};   // clean miss, fill takes 3 cycles
    vecs[4] = '{1, 0, 1, 2'b01, 2, 3, 7, 1};   // dirty miss write
    vecs[5] = '{0, 0, 2, 2'b01, 1, 1, 6, 2};   // miss again after refill
    vecs[6] = '{0, 0, 1, 2'b01, 1, 1, 4, 1};   // dirty miss, 1-cycle pmem

    #1;
    check("rst_state_dp_read", 32'(b.dp_read), 0);
    check("rst_state_pmem", 32'({b.pmem_read, b.pmem_write, b.pmem_addr_sel}), 0);
    check("rst_state_counts", 32'({b.hit_count, b.miss_count}), 0);
    repeat (2) @(negedge clk);
    rst = 0;

    for (int i = 0; i < 7; i++)
      do_txn($sformatf("vec%0d", i), vecs[i].wr, vecs[i].both, vecs[i].nmiss, vecs[i].dty,
             vecs[i].wl, vecs[i].fl, 1'b0, vecs[i].exp_lat, vecs[i].exp_fills);

    for (int i = 0; i < 40; i++) begin
      bit       wr, both;
      int       nmiss, wl, fl;
      bit [1:0] dty;
      wr    = 1'($urandom_range(0, 1));
      both  = ($urandom_range(0, 3) == 0);
      nmiss = $urandom_range(0, 2);
      dty   = 2'($urandom_range(0, 3));
      wl    = $urandom_range(1, 4);
      fl    = $urandom_range(1, 4);
      do_txn($sformatf("rnd%0d", i), wr, both, nmiss, dty, wl, fl, 1'b1,
             model_lat(nmiss, dty, wl, fl), nmiss);
    end

    // Reset in the middle of a writeback must drop pmem_write without a clock edge.
    @(negedge clk);
    b.mem_write = 1;
    @(negedge clk);
    b.hit = 0; b.dirty = 1;
    @(negedge clk);
    b.mem_write = 0;
    check("wb_entered", 32'({b.pmem_write, b.pmem_addr_sel}), 32'b11);
    #2 rst = 1;
    #1;
    check("rst_wb_pmem_write", 32'(b.pmem_write), 0);
    check("rst_wb_strobes", 32'({b.pmem_read, b.dp_read, b.mem_resp, b.dp_write, b.dp_fill}), 0);
    check("rst_wb_counts", 32'({b.hit_count, b.miss_count}), 0);
    b.dirty = 0;
    exp_hits = 0; exp_miss = 0;
    @(negedge clk);
    rst = 0;
    @(negedge clk);
    check("rst_wb_idle", 32'({b.dp_read, b.pmem_read, b.pmem_write}), 0);
    do_txn("post_rst", 0, 0, 0, 2'b00, 1, 1, 1'b0, 1, 0);

    // Saturation on the 2-bit instance: back-to-back read hits.
    @(negedge clk);
    b2.mem_read = 1; b2.hit = 1;
    repeat (10) @(posedge clk);
    #1;
    b2.mem_read = 0;
    check("sat_hit_count", 32'(b2.hit_count), 3);
    check("sat_miss_count", 32'(b2.miss_count), 0);
    @(negedge clk);
    b2.mem_read = 1;
    @(negedge clk);
    check("clr_in_compare", 32'(b2.dp_read), 1);
    b2.cnt_clr = 1;
    @(posedge clk);
    #1;
    b2.mem_read = 0; b2.cnt_clr = 0; b2.hit = 0;
    check("clr_beats_hit", 32'(b2.hit_count), 0);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
